// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: trap FSM encoding, cause codes, EX/MEM register layout.
// Latency/backpressure: not applicable (types and constants only).
package mips_pkg;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_TRAP = 1'b1;

    localparam logic [4:0] CAUSE_OV_DEFAULT = 5'd12;
    localparam logic [4:0] REG_ZERO         = 5'd0;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_res;
        logic        zero;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [4:0]  write_reg;
        logic [31:0] store_data;
    } exmem_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bundle: EX operands and pipeline controls in; registered MEM contents,
// forwarding source and exception status out. master = pipeline control side, slave = stage.
interface ex_mem_stage_if #(parameter int EPC_W = 32);

    logic             ex_valid;
    logic [31:0]      ex_aluRes;
    logic             ex_zero;
    logic             ex_overflow;
    logic             ex_ovfChk;
    logic             ex_regWrite;
    logic             ex_memRead;
    logic             ex_memWrite;
    logic             ex_memToReg;
    logic [4:0]       ex_writeReg;
    logic [31:0]      ex_storeData;
    logic [EPC_W-1:0] ex_pc;
    logic             stall;
    logic             flush;
    logic             exc_ack;

    logic             mem_valid;
    logic [31:0]      mem_aluRes;
    logic             mem_zero;
    logic             mem_regWrite;
    logic             mem_memRead;
    logic             mem_memWrite;
    logic             mem_memToReg;
    logic [4:0]       mem_writeReg;
    logic [31:0]      mem_storeData;
    logic             fwd_en;
    logic [4:0]       fwd_reg;
    logic [31:0]      fwd_data;
    logic             exc_valid;
    logic [4:0]       exc_cause;
    logic [EPC_W-1:0] exc_epc;

    modport master (
        output ex_valid, ex_aluRes, ex_zero, ex_overflow, ex_ovfChk, ex_regWrite,
               ex_memRead, ex_memWrite, ex_memToReg, ex_writeReg, ex_storeData, ex_pc,
               stall, flush, exc_ack,
        input  mem_valid, mem_aluRes, mem_zero, mem_regWrite, mem_memRead, mem_memWrite,
               mem_memToReg, mem_writeReg, mem_storeData, fwd_en, fwd_reg, fwd_data,
               exc_valid, exc_cause, exc_epc
    );

    modport slave (
        input  ex_valid, ex_aluRes, ex_zero, ex_overflow, ex_ovfChk, ex_regWrite,
               ex_memRead, ex_memWrite, ex_memToReg, ex_writeReg, ex_storeData, ex_pc,
               stall, flush, exc_ack,
        output mem_valid, mem_aluRes, mem_zero, mem_regWrite, mem_memRead, mem_memWrite,
               mem_memToReg, mem_writeReg, mem_storeData, fwd_en, fwd_reg, fwd_data,
               exc_valid, exc_cause, exc_epc
    );

endinterface

// File: rtl/ovf_trap_fsm.sv
// Overflow trap tracker: RUN/TRAP state plus the latched cause and EPC.
// Latency: trap visible on exc_* one cycle after the overflowing instruction is presented.
// Backpressure: holds the exception until exc_ack; forces bubbles into EX/MEM meanwhile.
module ovf_trap_fsm
    import mips_pkg::*;
#(
    parameter logic [4:0] CAUSE_OV = CAUSE_OV_DEFAULT,
    parameter int         EPC_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trap_req,
    input  logic             exc_ack,
    input  logic [EPC_W-1:0] ex_pc,
    output logic             bubble,
    output logic             exc_valid,
    output logic [4:0]       exc_cause,
    output logic [EPC_W-1:0] exc_epc
);

    logic [0:0]       state_q, state_d;
    logic [4:0]       cause_q, cause_d;
    logic [EPC_W-1:0] epc_q, epc_d;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        case (state_q)
            ST_RUN: begin
                if (trap_req) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_OV;
                    epc_d   = ex_pc;
                end
            end
            default: begin
                // Only the controller's acknowledge leaves TRAP; flush has no say here.
                if (exc_ack) begin
                    state_d = ST_RUN;
                    cause_d = '0;
                    epc_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    assign bubble    = (state_q == ST_TRAP) || trap_req;
    assign exc_valid = (state_q == ST_TRAP);
    assign exc_cause = cause_q;
    assign exc_epc   = epc_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with ALU-result forwarding; overflow trap enabled by EXMEM_OVF_TRAP_EN.
// Latency: one cycle from EX inputs to mem_* / fwd_*.
// Backpressure: stall holds the register; flush (higher priority) or a trap inserts a bubble.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter logic [4:0] CAUSE_OV = CAUSE_OV_DEFAULT,
    parameter int         EPC_W    = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_mem_stage_if.slave bus
);

    exmem_t ex_load;
    exmem_t mem_d, mem_q;
    logic   load_bubble;

    // Control bits of a non-instruction are squashed; data fields pass through as-is.
    always_comb begin
        ex_load            = '0;
        ex_load.valid      = bus.ex_valid;
        ex_load.alu_res    = bus.ex_aluRes;
        ex_load.zero       = bus.ex_zero;
        ex_load.reg_write  = bus.ex_valid & bus.ex_regWrite;
        ex_load.mem_read   = bus.ex_valid & bus.ex_memRead;
        ex_load.mem_write  = bus.ex_valid & bus.ex_memWrite;
        ex_load.mem_to_reg = bus.ex_valid & bus.ex_memToReg;
        ex_load.write_reg  = bus.ex_writeReg;
        ex_load.store_data = bus.ex_storeData;
    end

    always_comb begin
        mem_d = mem_q;
        if (bus.flush || load_bubble) begin
            mem_d = '0;
        end else if (!bus.stall) begin
            mem_d = ex_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef EXMEM_OVF_TRAP_EN
    logic trap_req;

    assign trap_req = bus.ex_valid & bus.ex_ovfChk & bus.ex_overflow & ~bus.stall & ~bus.flush;

    ovf_trap_fsm #(
        .CAUSE_OV (CAUSE_OV),
        .EPC_W    (EPC_W)
    ) u_ovf_trap_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .trap_req  (trap_req),
        .exc_ack   (bus.exc_ack),
        .ex_pc     (bus.ex_pc),
        .bubble    (load_bubble),
        .exc_valid (bus.exc_valid),
        .exc_cause (bus.exc_cause),
        .exc_epc   (bus.exc_epc)
    );
`else
    // Overflowing add/sub behaves like addu: it loads normally and never traps.
    logic unused_ok;

    assign unused_ok     = ^{bus.ex_ovfChk, bus.ex_overflow, bus.exc_ack, bus.ex_pc, CAUSE_OV};
    assign load_bubble   = 1'b0;
    assign bus.exc_valid = 1'b0;
    assign bus.exc_cause = '0;
    assign bus.exc_epc   = '0;
`endif

    assign bus.mem_valid     = mem_q.valid;
    assign bus.mem_aluRes    = mem_q.alu_res;
    assign bus.mem_zero      = mem_q.zero;
    assign bus.mem_regWrite  = mem_q.reg_write;
    assign bus.mem_memRead   = mem_q.mem_read;
    assign bus.mem_memWrite  = mem_q.mem_write;
    assign bus.mem_memToReg  = mem_q.mem_to_reg;
    assign bus.mem_writeReg  = mem_q.write_reg;
    assign bus.mem_storeData = mem_q.store_data;

    // Loads are excluded: their result is not known until after MEM.
    assign bus.fwd_en   = mem_q.valid & mem_q.reg_write & (mem_q.write_reg != REG_ZERO)
                        & ~mem_q.mem_to_reg;
    assign bus.fwd_reg  = mem_q.write_reg;
    assign bus.fwd_data = mem_q.alu_res;

endmodule
